// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches over a req/ready handshake with a timeout
// watchdog, and computes the next PC. Define IFU_PERF_CNT_EN for retired/taken counters.
module instruction_fetch_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  IMEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  output logic [31:0]         instr,
  output logic [5:0]          opcode,
  output logic [5:0]          func,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic                pc_src,
  input  logic                jSel,
  input  logic                pcSel,
  input  logic [PC_WIDTH-1:0] jr_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                fetch_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]         retired_cnt,
  output logic [31:0]         taken_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ERROR
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(IMEM_TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [7:0]          wait_cnt, wait_cnt_nxt;
  logic                load_ir;
  logic                retire;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] j_target;
  logic [PC_WIDTH-1:0] br_target;
  logic [PC_WIDTH-1:0] jr_aligned;
  logic signed [PC_WIDTH-1:0] br_off;

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_EXEC);
  assign fetch_err   = (state == S_ERROR);
  assign opcode      = instr[31:26];
  assign func        = instr[5:0];
  assign pc_plus4    = pc + PC_WIDTH'(4);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    load_ir      = 1'b0;
    retire       = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        // A ready on the final allowed cycle still completes the fetch.
        if (imem_ready) begin
          load_ir      = 1'b1;
          wait_cnt_nxt = 8'd0;
          state_nxt    = S_EXEC;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    jr_aligned     = jr_addr & ~PC_WIDTH'(3);
    br_off         = PC_WIDTH'(signed'({instr[15:0], 2'b00}));
    br_target      = pc_plus4 + $unsigned(br_off);
    j_target       = pc_plus4;
    j_target[27:0] = {instr[25:0], 2'b00};
    if (pcSel)       next_pc = jr_aligned;
    else if (!jSel)  next_pc = j_target;
    else if (pc_src) next_pc = br_target;
    else             next_pc = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      pc       <= RESET_PC;
      instr    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (load_ir) instr <= imem_rdata;
      if (retire)  pc    <= next_pc;
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Counters only move on retire, so they hold still once in ERROR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retired_cnt <= 32'd0;
      taken_cnt   <= 32'd0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 32'd1;
      if (next_pc != pc_plus4) taken_cnt <= taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit (IMEM_TIMEOUT=4) against a behavioural
// PC model; directed cases followed by randomized latency/control traffic.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        instr_valid;
  logic        exec_done;
  logic        pc_src;
  logic        jSel;
  logic        pcSel;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] taken_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mpc;
  logic [31:0] m_instr;
  int unsigned m_retired;
  int unsigned m_taken;

  instruction_fetch_unit #(
    .PC_WIDTH    (32),
    .RESET_PC    (32'h0000_0000),
    .IMEM_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .instr      (instr),
    .opcode     (opcode),
    .func       (func),
    .instr_valid(instr_valid),
    .exec_done  (exec_done),
    .pc_src     (pc_src),
    .jSel       (jSel),
    .pcSel      (pcSel),
    .jr_addr    (jr_addr),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_err  (fetch_err)
`ifdef IFU_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt),
    .taken_cnt  (taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next PC straight from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input bit ps, input bit js, input bit pcs,
                                             input logic [31:0] jr);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (pcs) return jr - (jr % 32'd4);
    if (!js) return (seq & 32'hF000_0000) + 32'(ins[25:0]) * 32'd4;
    if (ps)  return seq + 32'(signed'(ins[15:0])) * 32'd4;
    return seq;
  endfunction

  task automatic model_reset();
    mpc       = 32'h0;
    m_retired = 0;
    m_taken   = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; imem_ready = 1'b0; exec_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_err", fetch_err, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    model_reset();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] word, input int lat);
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, mpc);
    for (int i = 0; i < lat; i++) begin
      imem_ready = 1'b0; imem_rdata = $urandom; exec_done = 1'($urandom);
      @(negedge clk);
      chk("stall_req", imem_req, 1'b1);
      chk("stall_err", fetch_err, 1'b0);
    end
    imem_ready = 1'b1; imem_rdata = word; exec_done = 1'b0;
    @(negedge clk);
    imem_ready = 1'b0; imem_rdata = $urandom;
    m_instr = word;
    chk("ir_valid", instr_valid, 1'b1);
    chk("ir_word", instr, word);
    chk("opcode", 32'(opcode), 32'(word[31:26]));
    chk("func", 32'(func), 32'(word[5:0]));
    chk("ir_req_low", imem_req, 1'b0);
    chk("ir_err", fetch_err, 1'b0);
  endtask

  task automatic exec(input bit ps, input bit js, input bit pcs, input logic [31:0] jr,
                      input int hold);
    logic [31:0] exp;
    for (int i = 0; i < hold; i++) begin
      exec_done = 1'b0; pc_src = 1'($urandom); jSel = 1'($urandom); pcSel = 1'($urandom);
      jr_addr = $urandom; imem_ready = 1'($urandom); imem_rdata = $urandom;
      @(negedge clk);
      chk("hold_valid", instr_valid, 1'b1);
      chk("hold_ir", instr, m_instr);
      chk("hold_pc", pc, mpc);
    end
    imem_ready = 1'b0;
    pc_src = ps; jSel = js; pcSel = pcs; jr_addr = jr; exec_done = 1'b1;
    exp = model_next(mpc, m_instr, ps, js, pcs, jr);
    @(negedge clk);
    exec_done = 1'b0; pc_src = 1'($urandom); jSel = 1'($urandom); pcSel = 1'($urandom);
    jr_addr = $urandom;
    m_retired++;
    if (exp != mpc + 32'd4) m_taken++;
    mpc = exp;
    chk("done_valid", instr_valid, 1'b0);
    chk("next_pc", pc, mpc);
    chk("pc_plus4", pc_plus4, mpc + 32'd4);
    chk("refetch_req", imem_req, 1'b1);
  endtask

  initial begin
    logic [31:0] w;
    bit ps, js, pcs;
    rst = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
    pc_src = 1'b0; jSel = 1'b1; pcSel = 1'b0; jr_addr = 32'h0;
    model_reset();

    // Reset and sequential fetch
    do_reset();
    chk("first_req", imem_req, 1'b1);
    chk("seq_addr0", imem_addr, 32'h0);
    fetch(32'h0000_0020, 0); exec(1'b0, 1'b1, 1'b0, 32'h0, 0);
    chk("seq_addr1", imem_addr, 32'h4);
    fetch(32'h2108_0001, 0); exec(1'b0, 1'b1, 1'b0, 32'h0, 0);
    chk("seq_addr2", imem_addr, 32'h8);
    fetch(32'h0000_0025, 0); exec(1'b0, 1'b1, 1'b0, 32'h0, 0);

    // Branch taken / not taken at pc=0x10
    fetch(32'h0000_0008, 0); exec(1'b0, 1'b1, 1'b1, 32'h0000_0010, 1);
    chk("jr_to_10", pc, 32'h10);
    fetch(32'h1000_FFFE, 0); exec(1'b1, 1'b1, 1'b0, 32'h0, 0);
    chk("beq_taken", pc, 32'h0C);
    fetch(32'h0000_0008, 1); exec(1'b0, 1'b1, 1'b1, 32'h0000_0010, 0);
    fetch(32'h1000_FFFE, 1); exec(1'b0, 1'b1, 1'b0, 32'h0, 2);
    chk("beq_not_taken", pc, 32'h14);

    // Jump and jump register
    fetch(32'h0000_0008, 0); exec(1'b0, 1'b1, 1'b1, 32'h1000_0000, 0);
    fetch(32'h0800_0040, 2); exec(1'b0, 1'b0, 1'b0, 32'h0, 0);
    chk("j_target", pc, 32'h1000_0100);
    fetch(32'h0000_0008, 0); exec(1'b0, 1'b1, 1'b1, 32'h0000_2003, 0);
    chk("jr_aligned", pc, 32'h0000_2000);

    // Ready on the last allowed FETCH cycle
    fetch(32'hDEAD_BEEF, 3); exec(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 0);
    chk("wrap_plus4", pc_plus4, 32'h0);
    fetch(32'h0000_0000, 0); exec(1'b0, 1'b1, 1'b0, 32'h0, 0);
    chk("wrap_pc", pc, 32'h0);

    // Randomized latency and control traffic
    for (int n = 0; n < 40; n++) begin
      w   = $urandom;
      pcs = ($urandom_range(0, 3) == 0);
      js  = ($urandom_range(0, 3) != 0);
      ps  = 1'($urandom);
      fetch(w, int'($urandom_range(0, 3)));
      exec(ps, js, pcs, $urandom, int'($urandom_range(0, 2)));
    end
`ifdef IFU_PERF_CNT_EN
    chk("rand_retired", retired_cnt, m_retired);
    chk("rand_taken", taken_cnt, m_taken);
`endif

    // Reset mid-EXEC
    fetch(32'h1234_5678, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_exec_pc", pc, 32'h0);
    chk("mid_exec_valid", instr_valid, 1'b0);
    chk("mid_exec_instr", instr, 32'h0);
    chk("mid_exec_req", imem_req, 1'b0);
    rst = 1'b1; model_reset();
    @(negedge clk);

    // Reset mid-FETCH: the pending fetch is dropped
    chk("mf_req", imem_req, 1'b1);
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("mf_instr", instr, 32'h0);
    chk("mf_valid", instr_valid, 1'b0);
    rst = 1'b1; imem_ready = 1'b0;
    @(negedge clk);

    // Timeout: never ready
    chk("to_req0", imem_req, 1'b1);
    imem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_req3", imem_req, 1'b1);
    chk("to_err3", fetch_err, 1'b0);
    @(negedge clk);
    chk("to_err", fetch_err, 1'b1);
    chk("to_req", imem_req, 1'b0);
    chk("to_valid", instr_valid, 1'b0);
    imem_ready = 1'b1; exec_done = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    imem_ready = 1'b0; exec_done = 1'b0;
    chk("err_sticky", fetch_err, 1'b1);
    chk("err_req", imem_req, 1'b0);
    chk("err_valid", instr_valid, 1'b0);
    chk("err_pc", pc, mpc);
    chk("err_instr", instr, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("err_retired_frozen", retired_cnt, 32'd0);
`endif
    do_reset();
    chk("recover_req", imem_req, 1'b1);

`ifdef IFU_PERF_CNT_EN
    fetch(32'h0000_0020, 0); exec(1'b0, 1'b1, 1'b0, 32'h0, 0);
    fetch(32'h1000_0004, 1); exec(1'b1, 1'b1, 1'b0, 32'h0, 0);
    fetch(32'h0800_0100, 0); exec(1'b0, 1'b0, 1'b0, 32'h0, 1);
    fetch(32'h1000_FFF0, 2); exec(1'b1, 1'b1, 1'b0, 32'h0, 0);
    fetch(32'h0000_0025, 0); exec(1'b0, 1'b1, 1'b0, 32'h0, 0);
    chk("perf_retired", retired_cnt, 32'd5);
    chk("perf_taken", taken_cnt, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
